// File: rtl/cpu_pkg.sv
// Shared definitions for the issue stage in front of the 16-bit ALU:
// opcodes, instruction field positions and the issue FSM encoding.
package cpu_pkg;

    // Register-register operations (operand b from R[rt])
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    // Register-immediate operations (operand b from sign-extended imm)
    localparam logic [3:0] OP_ANDI = 4'd6;
    localparam logic [3:0] OP_ORI  = 4'd7;
    localparam logic [3:0] OP_XORI = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_SUBI = 4'd10;
    // ALU idle code: the ALU produces 0 for it
    localparam logic [3:0] OP_NOP  = 4'hF;

    // Instruction field positions (LSB of each field)
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS_LSB  = 6;
    localparam int RT_LSB  = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } issue_state_t;

    // Opcodes at or above ANDI take an immediate as operand b
    function automatic logic is_imm_op(input logic [3:0] op);
        return op >= OP_ANDI;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// Register file for the issue stage: NREGS x WIDTH, three asynchronous read
// ports (rs, rt, debug) and one synchronous write port. R0 is forced to zero.
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rs_addr,
    output logic [WIDTH-1:0] rs_data,
    input  logic [AW-1:0]    rt_addr,
    output logic [WIDTH-1:0] rt_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];

    // Next-state of the array: single write, R0 pinned to zero
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
        mem_d[0] = '0;
    end

    // Storage with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rs_data  = mem_q[rs_addr];
    assign rt_data  = mem_q[rt_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of the 16-bit ALU. One instruction in flight:
// IDLE accepts, READ fetches operands, EXEC drives the opcode for one cycle,
// WB writes back the ALU's registered result.
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE, and instr is
// sampled only on that edge.
// Optional feature: define FLAGS_REG_EN to add the flags_out status register.
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 6,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [3:0]       alu_codop,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             done,
    output logic [AW-1:0]    wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             illegal,
`ifdef FLAGS_REG_EN
    output logic [2:0]       flags_out,
`endif
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    issue_state_t     state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [3:0]       op;
    logic [AW-1:0]    rd, rs, rt;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] rs_data, rt_data;
    logic             rf_we;

    assign op      = instr_q[OP_LSB +: 4];
    assign rd      = instr_q[RD_LSB +: AW];
    assign rs      = instr_q[RS_LSB +: AW];
    assign rt      = instr_q[RT_LSB +: AW];
    assign imm     = instr_q[IMM_LSB +: IMM_W];
    assign imm_ext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef FLAGS_REG_EN
    logic [2:0] flags_q, flags_d;
    assign flags_out = flags_q;
`else
    // ALU status is not consumed in this build
    logic unused_alu_flags;
    assign unused_alu_flags = ^{alu_neg, alu_zero, alu_overflow};
`endif

    reg_file #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (alu_out),
        .rs_addr  (rs),
        .rs_data  (rs_data),
        .rt_addr  (rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // FSM next state, operand capture and per-state outputs
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        a_d         = a_q;
        b_d         = b_q;
        instr_ready = 1'b0;
        alu_codop   = OP_NOP;
        done        = 1'b0;
        illegal     = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        rf_we       = 1'b0;
`ifdef FLAGS_REG_EN
        flags_d     = flags_q;
`endif
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (op > OP_SUBI) begin
                    illegal = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    a_d     = rs_data;
                    b_d     = is_imm_op(op) ? imm_ext : rt_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_codop = op;
                state_d   = ST_WB;
            end
            ST_WB: begin
                // R0 writes are dropped inside the register file
                rf_we   = 1'b1;
                done    = 1'b1;
                wb_addr = rd;
                wb_data = alu_out;
`ifdef FLAGS_REG_EN
                flags_d = {alu_neg, alu_zero, alu_overflow};
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline registers; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef FLAGS_REG_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef FLAGS_REG_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign alu_a = a_q;
    assign alu_b = b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. The bench plays the ALU (registered result
// and flags) and keeps its own register model to predict writebacks.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  alu_codop;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        alu_neg, alu_zero, alu_overflow;
    logic        done;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef FLAGS_REG_EN
    logic [2:0]  flags_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [2:0]  addr_q[$];
    logic [15:0] model [8];

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_codop    (alu_codop),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_neg      (alu_neg),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .done         (done),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .illegal      (illegal),
`ifdef FLAGS_REG_EN
        .flags_out    (flags_out),
`endif
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ALU stand-in ----------------
    function automatic logic [15:0] alu_calc(input logic [3:0] c, input logic [15:0] a,
                                             input logic [15:0] b);
        case (c)
            4'd0, 4'd9:  return a + b;
            4'd1, 4'd10: return a - b;
            4'd2, 4'd6:  return a & b;
            4'd3, 4'd7:  return a | b;
            4'd4, 4'd8:  return a ^ b;
            4'd5:        return a << b[3:0];
            default:     return 16'h0000;
        endcase
    endfunction

    // {neg, zero, overflow}; for subtraction overflow reports the unsigned borrow
    function automatic logic [2:0] alu_flags(input logic [3:0] c, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] r;
        logic        ov;
        r  = alu_calc(c, a, b);
        ov = 1'b0;
        if (c == 4'd0 || c == 4'd9)  ov = (a[15] == b[15]) && (r[15] != a[15]);
        if (c == 4'd1 || c == 4'd10) ov = (a < b);
        return {r[15], (r == 16'h0000), ov};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out      <= 16'h0000;
            alu_neg      <= 1'b0;
            alu_zero     <= 1'b0;
            alu_overflow <= 1'b0;
        end else begin
            alu_out <= alu_calc(alu_codop, alu_a, alu_b);
            {alu_neg, alu_zero, alu_overflow} <= alu_flags(alu_codop, alu_a, alu_b);
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), dbg_data, model[i]);
        end
    endtask

    // ---------------- driver ----------------
    // Called with the DUT idle, between edges. Accepts one instruction and
    // follows it cycle by cycle until the stage is idle again.
    task automatic issue(input logic [15:0] w);
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt;
        logic [15:0] a, b, r, got_d;
        logic [2:0]  got_a;
        logic        ill;
        op  = w[15:12];
        rd  = w[11:9];
        rs  = w[8:6];
        rt  = w[5:3];
        ill = (op > 4'd10);
        a   = model[rs];
        b   = (op >= 4'd6) ? {{10{w[5]}}, w[5:0]} : model[rt];
        r   = alu_calc(op, a, b);

        check("ready_before_accept", {15'd0, instr_ready}, 16'd1);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        if (!ill) begin
            exp_q.push_back(r);
            addr_q.push_back(rd);
        end

        @(negedge clk);  // READ
        check("read_illegal", {15'd0, illegal}, {15'd0, ill});
        check("read_ready", {15'd0, instr_ready}, 16'd0);
        check("read_codop", {12'd0, alu_codop}, 16'h000F);
        check("read_done", {15'd0, done}, 16'd0);
        if (ill) begin
            @(negedge clk);
            check("ill_ready_after", {15'd0, instr_ready}, 16'd1);
            check("ill_done", {15'd0, done}, 16'd0);
            check("ill_pulse_end", {15'd0, illegal}, 16'd0);
            return;
        end

        @(negedge clk);  // EXEC
        check("exec_codop", {12'd0, alu_codop}, {12'd0, op});
        check("exec_a", alu_a, a);
        check("exec_b", alu_b, b);
        check("exec_done", {15'd0, done}, 16'd0);

        @(negedge clk);  // WB
        check("wb_done", {15'd0, done}, 16'd1);
        check("wb_codop", {12'd0, alu_codop}, 16'h000F);
        if (exp_q.size() > 0) begin
            got_d = exp_q.pop_front();
            got_a = addr_q.pop_front();
            check("wb_data", wb_data, got_d);
            check("wb_addr", {13'd0, wb_addr}, {13'd0, got_a});
        end
        if (rd != 3'd0) model[rd] = r;

        @(negedge clk);  // IDLE
        check("idle_done", {15'd0, done}, 16'd0);
        check("idle_ready", {15'd0, instr_ready}, 16'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] w;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", {15'd0, instr_ready}, 16'd1);
        check("rst_codop", {12'd0, alu_codop}, 16'h000F);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_illegal", {15'd0, illegal}, 16'd0);
        check("rst_wb_addr", {13'd0, wb_addr}, 16'd0);
        check("rst_wb_data", wb_data, 16'd0);
        check("rst_alu_a", alu_a, 16'd0);
        check("rst_alu_b", alu_b, 16'd0);
`ifdef FLAGS_REG_EN
        check("rst_flags", {13'd0, flags_out}, 16'd0);
`endif
        check_regs("rst");

        // addi R1,R0,5 then dependent add R2,R1,R1 issued back to back
        @(negedge clk);
        issue(16'h9205);
        issue(16'h0448);
        check_regs("dep");
        check("r1_is_5", model[1], 16'd5);
        check("r2_is_10", model[2], 16'd10);

        // addi R0,R0,-1: writeback reported, R0 unchanged
        @(negedge clk);
        issue(16'h903F);
        check_regs("r0wb");

        // Illegal opcode
        issue(16'hB000);
        check_regs("illegal");
        issue(16'hF1FF);

        // Random legal traffic against the register model
        for (int k = 0; k < 10; k++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 10));
            issue(w);
        end
        check_regs("rand");

        // Reset during EXEC of addi R3,R0,5
        instr_valid = 1'b1;
        instr       = 16'h9605;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);  // READ
        @(negedge clk);  // EXEC
        check("abort_exec_codop", {12'd0, alu_codop}, 16'h0009);
        rst = 1'b1;
        #1;
        check("abort_codop", {12'd0, alu_codop}, 16'h000F);
        check("abort_ready", {15'd0, instr_ready}, 16'd1);
        @(negedge clk);
        check("abort_done", {15'd0, done}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        @(negedge clk);
        check("abort_done2", {15'd0, done}, 16'd0);
        check_regs("abort");

`ifdef FLAGS_REG_EN
        // subi R4,R0,5: 0-5 -> neg, borrow
        @(negedge clk);
        issue(16'hA805);
        check("flags_subi", {13'd0, flags_out}, 16'b101);
        issue(16'hB000);
        check("flags_hold", {13'd0, flags_out}, 16'b101);
`endif

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
